// File: rtl/led_fader.sv
// led_fader: per-LED brightness with decaying afterglow, rendered as PWM drive.
// Ports:
//    i_clk    - clock, all state on the rising edge
//    i_rst_n  - asynchronous active-low reset
//    i_leds   - LED pattern from the upstream walker, sampled every cycle
//    o_leds   - registered PWM drive to the LED pins
// Build option: define LED_FADER_GAMMA_EN for squared (perceptual) duty.
module led_fader #(
   parameter int                  PWM_BITS     = 8,
   parameter logic [31:0]         DECAY_PERIOD = 32'd100_000,
   parameter logic [PWM_BITS-1:0] DECAY_STEP   = PWM_BITS'(16)
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_leds,
   output logic [7:0] o_leds
);
   localparam logic [PWM_BITS-1:0] MAX = '1;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [31:0]         decay_cnt;
   logic [PWM_BITS-1:0] bright [8];
   logic [PWM_BITS-1:0] duty [8];
   logic                decay_stb;
   assign decay_stb = decay_cnt == DECAY_PERIOD - 32'd1;
   always_comb begin
      for (int i = 0; i < 8; i++) begin
`ifdef LED_FADER_GAMMA_EN
         // upper half of the double-width square
         duty[i] = PWM_BITS'(({{PWM_BITS{1'b0}}, bright[i]} * {{PWM_BITS{1'b0}}, bright[i]}) >> PWM_BITS);
`else
         duty[i] = bright[i];
`endif
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pwm_cnt   <= '0;
         decay_cnt <= '0;
         o_leds    <= '0;
         for (int i = 0; i < 8; i++) bright[i] <= '0;
      end else begin
         pwm_cnt   <= pwm_cnt + 1'b1;
         decay_cnt <= decay_stb ? '0 : decay_cnt + 32'd1;
         for (int i = 0; i < 8; i++) begin
            // load beats decay; decay saturates at zero
            bright[i] <= i_leds[i] ? MAX
                       : decay_stb ? (bright[i] > DECAY_STEP ? bright[i] - DECAY_STEP : '0)
                       : bright[i];
            // full brightness is solid on, with no PWM gap
            o_leds[i] <= bright[i] == MAX ? 1'b1
                       : bright[i] == '0 ? 1'b0
                       : pwm_cnt < duty[i];
         end
      end
   end
endmodule
